line_burst_adaptor: RTL and testbench
=====================================

LINE_BURST_ADAPTOR -- requirements
Module: line_burst_adaptor

Interface
REQ-001 SHALL have parameter LINE_W, default 256, meaning cache line width in bits.
REQ-002 SHALL have parameter BURST_W, default 64, meaning memory beat width; BEATS = LINE_W/BURST_W (default 4).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (rst==0 resets on the clk edge).
REQ-005 SHALL have port read_i  input  1  cache line fill request, held until resp_o.
REQ-006 SHALL have port write_i  input  1  cache line writeback request, held until resp_o.
REQ-007 SHALL have port address_i  input  32  line address from the cache.
REQ-008 SHALL have port line_i  input  LINE_W  writeback data.
REQ-009 SHALL have port line_o  output  LINE_W  fill data, valid while resp_o=1.
REQ-010 SHALL have port resp_o  output  1  one-cycle completion pulse to the cache.
REQ-011 SHALL have port read_o / write_o  output  1 each  memory burst request, held for the whole burst.
REQ-012 SHALL have port address_o  output  32  line-aligned memory address.
REQ-013 SHALL have port burst_i  input  BURST_W  memory read beat, valid when resp_i=1.
REQ-014 SHALL have port burst_o  output  BURST_W  current write beat.
REQ-015 SHALL have port resp_i  input  1  per-beat memory acknowledge.

Function
REQ-016 SHALL implement FSM states IDLE, RD_BURST, WR_BURST, DONE.
REQ-017 IDLE: write_i=1 -> WR_BURST (write wins if read_i and write_i both 1); else read_i=1 -> RD_BURST; else stay.
REQ-018 On request acceptance SHALL latch address_o = {address_i[31:log2(LINE_W/8)], zeros}, latch line_i on writes, and clear beat counter to 0.
REQ-019 RD_BURST: read_o=1; each cycle with resp_i=1 SHALL store burst_i into line bits [k*BURST_W +: BURST_W] for beat k and increment k.
REQ-020 WR_BURST: write_o=1; burst_o SHALL equal latched line beat k; each resp_i=1 increments k.
REQ-021 When resp_i=1 on beat k=BEATS-1, next state SHALL be DONE; beat counter wraps to 0.
REQ-022 DONE: resp_o=1 for exactly one cycle, line_o holds assembled line; next state IDLE.
REQ-023 Minimum latency: request at cycle 0, read_o/write_o from cycle 1, with resp_i held high resp_o at cycle 1+BEATS.
REQ-024 resp_i in IDLE or DONE SHALL be ignored; read_o and write_o SHALL never be 1 simultaneously.
REQ-025 Requests arriving while not in IDLE SHALL be ignored until return to IDLE; a request still held in the IDLE cycle after DONE starts a new transaction.

Reset
REQ-026 rst==0 SHALL force IDLE, beat counter 0, read_o=write_o=resp_o=0, address_o=0, burst_o=0, line_o=0.
REQ-027 Reset mid-burst SHALL abandon the transaction with no resp_o; partial line data is cleared.

Configuration
REQ-028 With LBA_PERF_CNT_EN defined, SHALL add outputs rd_count_o and wr_count_o (32 bits each, input-free counters), incremented in DONE per completed read/write, cleared by reset, wrapping at 2^32.
REQ-029 Without LBA_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-030 Shared package lba_pkg SHALL hold LINE_W/BURST_W defaults, BEATS, beat-index width, and the state enum type.
REQ-031 Beat storage SHALL be sub-module line_beat_buffer (line register with beat-indexed write, beat-indexed read, full-line load).

Verification
REQ-032 Read, resp_i always 1, beats 0x11..,0x22..,0x33..,0x44.. -> line_o={0x44..,0x33..,0x22..,0x11..}, resp_o at cycle 5.
REQ-033 Write line 0xDDDD..CCCC..BBBB..AAAA, resp_i every other cycle -> burst_o order AAAA,BBBB,CCCC,DDDD; resp_o after 4th ack only.
REQ-034 read_i=write_i=1 with address_i=0x1234_567F -> write_o=1, read_o=0, address_o=0x1234_5660.
REQ-035 rst=0 after 2 read beats -> next cycle IDLE, read_o=0, no resp_o; new read completes normally.
REQ-036 resp_i pulsed in IDLE and DONE -> no state change, counter stays 0; with LBA_PERF_CNT_EN, two reads and one write -> rd_count_o=2, wr_count_o=1.

Source files
------------

// File: rtl/lba_pkg.sv
// Shared types and defaults for the cache-line / memory-burst adaptor.
package lba_pkg;

  localparam int LBA_LINE_W     = 256;
  localparam int LBA_BURST_W    = 64;
  localparam int LBA_BEATS      = LBA_LINE_W / LBA_BURST_W;
  localparam int LBA_BEAT_IDX_W = (LBA_BEATS > 1) ? $clog2(LBA_BEATS) : 1;
  localparam int LBA_ADDR_W     = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } lba_state_e;

  // Beat-index width for an arbitrary beat count; a single-beat line still needs one bit.
  function automatic int lba_beat_idx_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/line_burst_adaptor_if.sv
// Bus bundles for the adaptor: the cache-side line port and the memory-side burst port.
interface lba_cache_if
  import lba_pkg::*;
#(
  parameter int LINE_W = LBA_LINE_W
);
  logic                  read_i;
  logic                  write_i;
  logic [LBA_ADDR_W-1:0] address_i;
  logic [LINE_W-1:0]     line_i;
  logic [LINE_W-1:0]     line_o;
  logic                  resp_o;

  modport master (
    output read_i, write_i, address_i, line_i,
    input  line_o, resp_o
  );

  modport slave (
    input  read_i, write_i, address_i, line_i,
    output line_o, resp_o
  );
endinterface

interface lba_mem_if
  import lba_pkg::*;
#(
  parameter int BURST_W = LBA_BURST_W
);
  logic                  read_o;
  logic                  write_o;
  logic [LBA_ADDR_W-1:0] address_o;
  logic [BURST_W-1:0]    burst_o;
  logic [BURST_W-1:0]    burst_i;
  logic                  resp_i;

  modport master (
    output read_o, write_o, address_o, burst_o,
    input  burst_i, resp_i
  );

  modport slave (
    input  read_o, write_o, address_o, burst_o,
    output burst_i, resp_i
  );
endinterface

// File: rtl/line_beat_buffer.sv
// One cache line of storage: full-line load, beat-indexed write and beat-indexed read.
module line_beat_buffer
  import lba_pkg::*;
#(
  parameter int LINE_W  = LBA_LINE_W,
  parameter int BURST_W = LBA_BURST_W,
  parameter int IDX_W   = LBA_BEAT_IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [LINE_W-1:0]  i_line,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [BURST_W-1:0] i_wr_beat,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic [BURST_W-1:0] o_rd_beat,
  output logic [LINE_W-1:0]  o_line
);

  logic [LINE_W-1:0] r_line;

  // A full-line load takes priority; the FSM never asserts both in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_line;
    end else if (i_wr_en) begin
      r_line[int'(i_wr_idx)*BURST_W +: BURST_W] <= i_wr_beat;
    end
  end

  assign o_rd_beat = r_line[int'(i_rd_idx)*BURST_W +: BURST_W];
  assign o_line    = r_line;

endmodule

// File: rtl/line_burst_adaptor.sv
// Converts single-cycle cache line requests into BEATS-long memory bursts.
// Optional LBA_PERF_CNT_EN adds completed read/write counters rd_count_o / wr_count_o.
module line_burst_adaptor
  import lba_pkg::*;
#(
  parameter int LINE_W  = LBA_LINE_W,
  parameter int BURST_W = LBA_BURST_W
) (
  input  logic        clk,
  input  logic        rst,
  lba_cache_if.slave  cache,
  lba_mem_if.master   mem
`ifdef LBA_PERF_CNT_EN
  ,
  output logic [31:0] rd_count_o,
  output logic [31:0] wr_count_o
`endif
);

  localparam int BEATS = LINE_W / BURST_W;
  localparam int IDX_W = lba_beat_idx_w(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);

  localparam logic [IDX_W-1:0]      LAST_BEAT = IDX_W'(BEATS - 1);
  localparam logic [LBA_ADDR_W-1:0] ADDR_MASK = ~((LBA_ADDR_W'(1) << OFF_W) - LBA_ADDR_W'(1));

  lba_state_e             r_state;
  lba_state_e             w_state_nxt;
  logic [IDX_W-1:0]       r_beat;
  logic [LBA_ADDR_W-1:0]  r_addr;

  logic                   w_accept;
  logic                   w_beat_fire;
  logic                   w_load;
  logic                   w_store;
  logic [BURST_W-1:0]     w_rd_beat;
  logic [LINE_W-1:0]      w_line;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_addr <= cache.address_i & ADDR_MASK;
        r_beat <= '0;
      end else if (w_beat_fire) begin
        r_beat <= (r_beat == LAST_BEAT) ? '0 : r_beat + IDX_W'(1);
      end
    end
  end

  // Write wins over read when both are presented in IDLE; acks outside a burst are dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_beat_fire = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (cache.write_i) begin
          w_state_nxt = WR_BURST;
          w_accept    = 1'b1;
        end else if (cache.read_i) begin
          w_state_nxt = RD_BURST;
          w_accept    = 1'b1;
        end
      end
      RD_BURST, WR_BURST: begin
        if (mem.resp_i) begin
          w_beat_fire = 1'b1;
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_load  = w_accept & cache.write_i;
  assign w_store = w_beat_fire & (r_state == RD_BURST);

  line_beat_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W),
    .IDX_W   (IDX_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_line    (cache.line_i),
    .i_wr_en   (w_store),
    .i_wr_idx  (r_beat),
    .i_wr_beat (mem.burst_i),
    .i_rd_idx  (r_beat),
    .o_rd_beat (w_rd_beat),
    .o_line    (w_line)
  );

  assign mem.read_o    = (r_state == RD_BURST);
  assign mem.write_o   = (r_state == WR_BURST);
  assign mem.address_o = r_addr;
  assign mem.burst_o   = (r_state == WR_BURST) ? w_rd_beat : '0;

  assign cache.resp_o  = (r_state == DONE);
  assign cache.line_o  = w_line;

`ifdef LBA_PERF_CNT_EN
  logic        r_is_wr;
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_is_wr    <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_accept) begin
        r_is_wr <= cache.write_i;
      end
      if (r_state == DONE) begin
        if (r_is_wr) begin
          r_wr_count <= r_wr_count + 32'd1;
        end else begin
          r_rd_count <= r_rd_count + 32'd1;
        end
      end
    end
  end

  assign rd_count_o = r_rd_count;
  assign wr_count_o = r_wr_count;
`endif

endmodule

// File: tb/tb_line_burst_adaptor.sv
// Scoreboard bench for line_burst_adaptor: drives cache requests, models the memory side.
module tb_line_burst_adaptor;
  import lba_pkg::*;

  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam logic [31:0] ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);

  typedef logic [LINE_W-1:0] val_t;
  typedef struct {
    bit   is_rd;
    val_t line;
    int   c0;
    bit   fast;
  } txn_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   exp_rd;
  int   exp_wr;
  txn_t txn_q[$];
  val_t beat_q[$];

  lba_cache_if #(.LINE_W(LINE_W))   cache_if ();
  lba_mem_if   #(.BURST_W(BURST_W)) mem_if ();

`ifdef LBA_PERF_CNT_EN
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`endif

  line_burst_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .cache (cache_if),
    .mem   (mem_if)
`ifdef LBA_PERF_CNT_EN
    ,
    .rd_count_o (rd_count),
    .wr_count_o (wr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input val_t act, input val_t exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Memory-side monitor: pops expected write beats and completed lines.
  initial begin
    int   ack_cnt;
    txn_t t;
    val_t b;
    ack_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        ack_cnt = 0;
        exp_rd  = 0;
        exp_wr  = 0;
      end else begin
        check("rw_excl", val_t'(mem_if.read_o & mem_if.write_o), val_t'(0));
        if ((mem_if.read_o || mem_if.write_o) && mem_if.resp_i) begin
          ack_cnt++;
          if (mem_if.write_o) begin
            check("beat_expected", val_t'(beat_q.size() != 0), val_t'(1));
            if (beat_q.size() != 0) begin
              b = beat_q.pop_front();
              check("burst_o", val_t'(mem_if.burst_o), b);
            end
          end
        end
        if (cache_if.resp_o) begin
          check("resp_expected", val_t'(txn_q.size() != 0), val_t'(1));
          if (txn_q.size() != 0) begin
            t = txn_q.pop_front();
            check("acks_before_resp", val_t'(ack_cnt), val_t'(BEATS));
            if (t.is_rd) begin
              check("line_o", cache_if.line_o, t.line);
              exp_rd++;
            end else begin
              exp_wr++;
            end
            if (t.fast) check("latency", val_t'(cyc - t.c0), val_t'(1 + BEATS));
          end
          ack_cnt = 0;
        end
      end
    end
  end

  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input val_t line, input bit fast);
    txn_t t;
    int   n;
    int   acks;
    bit   tog;
    bit   first;
    bit   done;
    @(posedge clk); #1;
    cache_if.read_i    = rd;
    cache_if.write_i   = wr;
    cache_if.address_i = addr;
    cache_if.line_i    = line;
    t.is_rd = !wr;
    t.line  = line;
    t.c0    = cyc;
    t.fast  = fast;
    txn_q.push_back(t);
    if (wr) for (int k = 0; k < BEATS; k++) beat_q.push_back(val_t'(line[k*BURST_W +: BURST_W]));
    n = 0; acks = 0; tog = 1'b0; first = 1'b1; done = 1'b0;
    while (!done && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (cache_if.resp_o) begin
        done = 1'b1;
      end else if (mem_if.read_o || mem_if.write_o) begin
        if (first) begin
          check("dir_write_o", val_t'(mem_if.write_o), val_t'(wr));
          check("dir_read_o", val_t'(mem_if.read_o), val_t'(!wr));
          check("address_o", val_t'(mem_if.address_o), val_t'(addr & ADDR_MASK));
          first = 1'b0;
        end
        tog = fast ? 1'b1 : ~tog;
        mem_if.resp_i  = tog;
        mem_if.burst_i = line[acks*BURST_W +: BURST_W];
        if (tog) acks++;
      end
    end
    check("txn_done", val_t'(done), val_t'(1));
    cache_if.read_i  = 1'b0;
    cache_if.write_i = 1'b0;
    mem_if.resp_i    = 1'b0;
  endtask

  function automatic val_t rand_line();
    val_t l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom();
    return l;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; exp_rd = 0; exp_wr = 0;
    rst = 1'b0;
    cache_if.read_i = 1'b0; cache_if.write_i = 1'b0;
    cache_if.address_i = '0; cache_if.line_i = '0;
    mem_if.burst_i = '0; mem_if.resp_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read_o", val_t'(mem_if.read_o), val_t'(0));
    check("rst_write_o", val_t'(mem_if.write_o), val_t'(0));
    check("rst_resp_o", val_t'(cache_if.resp_o), val_t'(0));
    check("rst_address_o", val_t'(mem_if.address_o), val_t'(0));
    check("rst_burst_o", val_t'(mem_if.burst_o), val_t'(0));
    check("rst_line_o", cache_if.line_o, val_t'(0));
    rst = 1'b1;

    txn(1'b1, 1'b0, 32'h0000_1000,
        {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b1);
    txn(1'b0, 1'b1, 32'h0000_2020,
        {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1'b0);

    // Both requests at once: write must win and the address is line-aligned.
    @(posedge clk); #1;
    cache_if.read_i = 1'b1; cache_if.write_i = 1'b1;
    cache_if.address_i = 32'h1234_567F;
    @(posedge clk); #1;
    check("both_write_o", val_t'(mem_if.write_o), val_t'(1));
    check("both_read_o", val_t'(mem_if.read_o), val_t'(0));
    check("both_address_o", val_t'(mem_if.address_o), val_t'(32'h1234_5660));
    cache_if.read_i = 1'b0; cache_if.write_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    txn(1'b1, 1'b1, 32'h1234_567F, rand_line(), 1'b1);

    // Reset after two read beats abandons the burst.
    @(posedge clk); #1;
    cache_if.read_i = 1'b1; cache_if.address_i = 32'h2000_0040;
    @(posedge clk); #1;
    check("mid_read_o", val_t'(mem_if.read_o), val_t'(1));
    mem_if.resp_i = 1'b1; mem_if.burst_i = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1;
    mem_if.burst_i = 64'hFEDC_BA98_7654_3210;
    @(posedge clk); #1;
    rst = 1'b0; mem_if.resp_i = 1'b0; cache_if.read_i = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_read_o", val_t'(mem_if.read_o), val_t'(0));
    check("mid_rst_resp_o", val_t'(cache_if.resp_o), val_t'(0));
    check("mid_rst_line_o", cache_if.line_o, val_t'(0));
    check("mid_rst_address_o", val_t'(mem_if.address_o), val_t'(0));
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_no_resp_o", val_t'(cache_if.resp_o), val_t'(0));
    end
    txn(1'b1, 1'b0, 32'h2000_0040, rand_line(), 1'b1);

    // Acks while idle must not move the FSM or the beat counter.
    @(posedge clk); #1;
    mem_if.resp_i = 1'b1; mem_if.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle_ack_read_o", val_t'(mem_if.read_o), val_t'(0));
      check("idle_ack_write_o", val_t'(mem_if.write_o), val_t'(0));
      check("idle_ack_resp_o", val_t'(cache_if.resp_o), val_t'(0));
    end
    mem_if.resp_i = 1'b0;
    txn(1'b1, 1'b0, 32'h0000_3000, rand_line(), 1'b0);

    for (int i = 0; i < 6; i++) begin
      bit w;
      w = 1'($urandom_range(0, 1));
      txn(!w, w, $urandom(), rand_line(), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", val_t'(txn_q.size() + beat_q.size()), val_t'(0));
`ifdef LBA_PERF_CNT_EN
    check("rd_count_o", val_t'(rd_count), val_t'(exp_rd));
    check("wr_count_o", val_t'(wr_count), val_t'(exp_wr));
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
